vga_sync_gen: RTL and testbench
===============================

Name: vga_sync_gen

Overview:
- Video timing generator that produces the hblank/vblank status consumed by the VGA register block and the hsync/vsync pins driven to the monitor.
- Gated by vga_en, the enable bit written by the CPU into the VGA control register.
- Advances one pixel per pix_ce pulse on the single system clock, and supplies the pixel coordinates to the frame-buffer reader.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of hsync/vsync (0 = active-low)
CW, 10, width of hcnt/vcnt; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
clk  input  1  global clock
rst  input  1  synchronous reset, active-high
pix_ce  input  1  pixel clock enable, one pulse per pixel period
vga_en  input  1  module enable from the VGA control register
hcnt  output  CW  current pixel column, 0..H_TOTAL-1
vcnt  output  CW  current line, 0..V_TOTAL-1
de  output  1  display enable: hcnt<H_ACTIVE and vcnt<V_ACTIVE
hblank  output  1  1 when hcnt>=H_ACTIVE
vblank  output  1  1 when vcnt>=V_ACTIVE
hsync  output  1  SYNC_POL when H_ACTIVE+H_FP <= hcnt < H_ACTIVE+H_FP+H_SYNC, else ~SYNC_POL
vsync  output  1  SYNC_POL when V_ACTIVE+V_FP <= vcnt < V_ACTIVE+V_FP+V_SYNC, else ~SYNC_POL
frame_start  output  1  one-clk pulse when counters step to (0,0)

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Region order within a line and within a frame is fixed: active, front porch, sync, back porch.
- All outputs are flops.
- hcnt and vcnt are the counter registers themselves.
- de, hblank, vblank, hsync and vsync are registered decodes of the next-state counter values, so in every cycle they correspond exactly to the hcnt/vcnt presented in that same cycle. There is no decode lag.
- Reset, and the disabled state (vga_en=0), both force: hcnt=0, vcnt=0, de=0, hblank=1, vblank=1, hsync=~SYNC_POL, vsync=~SYNC_POL, frame_start=0.
- rst has priority over everything else.
- State machine:
  - IDLE: vga_en=0; hold the reset values.
  - SYNC_WAIT: vga_en=1, waiting for the first pix_ce.
  - RUN: counting.
- IDLE -> SYNC_WAIT when vga_en=1.
- SYNC_WAIT -> RUN on the first clk with pix_ce=1. In that clk the counters load (0,0) and frame_start=1, so the decodes give de=1, hblank=0, vblank=0.
- In RUN, each clk with pix_ce=1 does the following:
  - If hcnt<H_TOTAL-1, then hcnt+1.
  - Otherwise hcnt=0, and vcnt advances: vcnt+1 if vcnt<V_TOTAL-1, else vcnt=0.
  - frame_start=1 in the clk where the counters step from (H_TOTAL-1, V_TOTAL-1) to (0,0).
- Clks with pix_ce=0 hold the counters and all decoded outputs; frame_start=0.
- frame_start is never high for more than one clk.
- Any state -> IDLE in the clk after vga_en is sampled 0. A line or frame in progress is abandoned: outputs return to the idle values and there is no partial sync pulse completion.
- Re-enable always restarts from (0,0) on the next pix_ce.
- vga_en and pix_ce are sampled synchronously; both may toggle on any clk.
- pix_ce held at 1 is legal (pixel rate equals clk rate).
- Reset mid-frame: the next clk shows the reset values. The block stays IDLE until vga_en is seen high after rst deasserts.
- Parameter legality (not checked in RTL): every porch, sync and active width >= 1.

Test Plan:
All scenarios use small parameters: H_ACTIVE=8, H_FP=2, H_SYNC=3, H_BP=3 (H_TOTAL=16); V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=1 (V_TOTAL=8); SYNC_POL=0; CW=5.
1. Reset with vga_en=1 and pix_ce=1 -> during rst and the clk after it: hcnt=0, vcnt=0, de=0, hblank=1, vblank=1, hsync=1, vsync=1. The first pix_ce after release gives (0,0), frame_start=1, de=1.
2. pix_ce=1 continuously, one line -> de=1 for hcnt 0..7; hblank=1 for hcnt 8..15; hsync=0 exactly for hcnt 10..12 (3 clks); vcnt steps 0->1 when hcnt wraps 15->0.
3. Full frame -> vblank=1 for vcnt 4..7; vsync=0 for vcnt 5..6 (2 lines = 32 pix_ce); frame_start pulses once every 128 pix_ce; vcnt wraps 7->0.
4. pix_ce asserted every 4th clk -> counters and outputs change only in pix_ce clks; the hsync low width is 12 clks; frame_start stays 1 clk wide.
5. Drop vga_en at (hcnt=11, vcnt=5), i.e. inside both sync pulses -> the next clk shows hsync=1, vsync=1, blanks=1, counters (0,0). Re-assert vga_en -> restart at (0,0) with frame_start=1.
6. Assert rst at (hcnt=3, vcnt=2) with vga_en held at 1 -> the next clk shows the idle values. After rst deasserts, counting resumes from (0,0) with frame_start=1.

Source files
------------

// File: rtl/vga_sync_gen.sv
// VGA timing generator: pixel/line counters with registered blank, sync and
// display-enable decodes that always match the counter values shown with them.
module vga_sync_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit SYNC_POL = 1'b0,
    parameter int CW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_ce,
    input  logic          vga_en,
    output logic [CW-1:0] hcnt,
    output logic [CW-1:0] vcnt,
    output logic          de,
    output logic          hblank,
    output logic          vblank,
    output logic          hsync,
    output logic          vsync,
    output logic          frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CW-1:0] H_LAST = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_LAST = CW'(V_TOTAL - 1);
    localparam logic [CW-1:0] H_VIS  = CW'(H_ACTIVE);
    localparam logic [CW-1:0] V_VIS  = CW'(V_ACTIVE);
    localparam logic [CW-1:0] HS_BEG = CW'(H_ACTIVE + H_FP);
    localparam logic [CW-1:0] HS_END = CW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [CW-1:0] VS_BEG = CW'(V_ACTIVE + V_FP);
    localparam logic [CW-1:0] VS_END = CW'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        IDLE,
        SYNC_WAIT,
        RUN
    } state_t;

    state_t        state;
    logic [CW-1:0] h_next;
    logic [CW-1:0] v_next;
    logic          wrap_frame;

    // Next counter position; decodes are taken from this so they never lag.
    always_comb begin
        h_next     = hcnt;
        v_next     = vcnt;
        wrap_frame = 1'b0;
        if (state == SYNC_WAIT) begin
            h_next     = '0;
            v_next     = '0;
            wrap_frame = 1'b1;
        end else if (hcnt < H_LAST) begin
            h_next = hcnt + CW'(1);
        end else begin
            h_next = '0;
            if (vcnt < V_LAST) begin
                v_next = vcnt + CW'(1);
            end else begin
                v_next     = '0;
                wrap_frame = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !vga_en) begin
            state       <= IDLE;
            hcnt        <= '0;
            vcnt        <= '0;
            de          <= 1'b0;
            hblank      <= 1'b1;
            vblank      <= 1'b1;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
        end else begin
            frame_start <= 1'b0;
            case (state)
                IDLE: state <= SYNC_WAIT;
                SYNC_WAIT, RUN: begin
                    if (pix_ce) begin
                        state       <= RUN;
                        hcnt        <= h_next;
                        vcnt        <= v_next;
                        de          <= (h_next < H_VIS) && (v_next < V_VIS);
                        hblank      <= (h_next >= H_VIS);
                        vblank      <= (v_next >= V_VIS);
                        hsync       <= ((h_next >= HS_BEG) && (h_next < HS_END)) ? SYNC_POL : ~SYNC_POL;
                        vsync       <= ((v_next >= VS_BEG) && (v_next < VS_END)) ? SYNC_POL : ~SYNC_POL;
                        frame_start <= wrap_frame;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a linear pixel-index frame model checked every cycle,
// plus directed literal checks on reset, line/frame shape, slow pix_ce and aborts.
module tb_vga_sync_gen;

    localparam int HA = 8, HF = 2, HS = 3, HB = 3;
    localparam int VA = 4, VF = 1, VS = 2, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pix_ce = 1'b0;
    logic          vga_en = 1'b0;
    logic [CW-1:0] hcnt;
    logic [CW-1:0] vcnt;
    logic          de, hblank, vblank, hsync, vsync, frame_start;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 1'b0;

    // 0 = off, 1 = armed (enabled, waiting for pix_ce), 2 = running
    int m_state = 0;
    int m_idx = 0;
    bit m_fs = 1'b0;
    int e_h, e_v;
    bit e_run;

    vga_sync_gen #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .pix_ce(pix_ce), .vga_en(vga_en),
        .hcnt(hcnt), .vcnt(vcnt), .de(de), .hblank(hblank), .vblank(vblank),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input bit r, input bit e, input bit c);
        rst    = r;
        vga_en = e;
        pix_ce = c;
        @(posedge clk);
        #1;
    endtask

    // Frame position kept as one linear pixel index; wraps modulo the frame size.
    always @(posedge clk) begin
        m_fs <= 1'b0;
        if (rst || !vga_en) begin
            m_state <= 0;
            m_idx   <= 0;
        end else if (m_state == 0) begin
            m_state <= 1;
        end else if (pix_ce) begin
            m_state <= 2;
            if (m_state == 1) begin
                m_idx <= 0;
                m_fs  <= 1'b1;
            end else begin
                m_idx <= (m_idx + 1) % FRAME;
                m_fs  <= (m_idx == FRAME - 1);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            e_run = (m_state == 2);
            e_h   = e_run ? m_idx % HT : 0;
            e_v   = e_run ? m_idx / HT : 0;
            checkOutput("hcnt", int'(hcnt), e_h);
            checkOutput("vcnt", int'(vcnt), e_v);
            checkOutput("de", int'(de), int'(e_run && e_h < HA && e_v < VA));
            checkOutput("hblank", int'(hblank), int'(!e_run || e_h >= HA));
            checkOutput("vblank", int'(vblank), int'(!e_run || e_v >= VA));
            checkOutput("hsync", int'(hsync),
                        int'(!(e_run && e_h >= HA + HF && e_h < HA + HF + HS)));
            checkOutput("vsync", int'(vsync),
                        int'(!(e_run && e_v >= VA + VF && e_v < VA + VF + VS)));
            checkOutput("frame_start", int'(frame_start), int'(m_fs));
        end
    end

    task automatic runTo(input int h, input int v);
        int k = 0;
        while (!(int'(hcnt) == h && int'(vcnt) == v) && k < 4 * FRAME) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            k++;
        end
        checkOutput("reach_position", int'(int'(hcnt) == h && int'(vcnt) == v), 1);
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_hcnt"}, int'(hcnt), 0);
        checkOutput({tag, "_vcnt"}, int'(vcnt), 0);
        checkOutput({tag, "_de"}, int'(de), 0);
        checkOutput({tag, "_hblank"}, int'(hblank), 1);
        checkOutput({tag, "_vblank"}, int'(vblank), 1);
        checkOutput({tag, "_hsync"}, int'(hsync), 1);
        checkOutput({tag, "_vsync"}, int'(vsync), 1);
        checkOutput({tag, "_fs"}, int'(frame_start), 0);
    endtask

    task automatic checkRestart(input string tag);
        checkOutput({tag, "_fs"}, int'(frame_start), 1);
        checkOutput({tag, "_hcnt"}, int'(hcnt), 0);
        checkOutput({tag, "_vcnt"}, int'(vcnt), 0);
        checkOutput({tag, "_de"}, int'(de), 1);
        checkOutput({tag, "_hblank"}, int'(hblank), 0);
    endtask

    initial begin
        int de_n, hb_n, hs_n, hs_first, n, vs_low, vb_n, k, w, mode;
        bit r, e, c;

        // Reset with enable and pix_ce high
        applyStimulus(1'b1, 1'b1, 1'b1);
        chk_on = 1'b1;
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkIdle("rst_hold");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkIdle("rst_after");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkRestart("rst_first_pix");

        // One line with pix_ce continuously high
        de_n = 0; hb_n = 0; hs_n = 0; hs_first = -1;
        for (int i = 0; i < HT; i++) begin
            if (i > 0) applyStimulus(1'b0, 1'b1, 1'b1);
            de_n += int'(de);
            hb_n += int'(hblank);
            if (!hsync) begin
                hs_n++;
                if (hs_first < 0) hs_first = int'(hcnt);
            end
        end
        checkOutput("line_de_count", de_n, 8);
        checkOutput("line_hblank_count", hb_n, 8);
        checkOutput("line_hsync_low", hs_n, 3);
        checkOutput("line_hsync_first", hs_first, 10);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("line_wrap_h", int'(hcnt), 0);
        checkOutput("line_wrap_v", int'(vcnt), 1);

        // Full frame: frame_start period and vertical region sizes
        n = 0;
        while (!frame_start && n < 2 * FRAME) begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
        end
        checkOutput("first_frame_gap", n, 112);
        n = 0; vs_low = 0; vb_n = 0;
        do begin
            applyStimulus(1'b0, 1'b1, 1'b1);
            n++;
            vs_low += int'(!vsync);
            vb_n   += int'(vblank);
        end while (!frame_start && n < 2 * FRAME);
        checkOutput("frame_period", n, 128);
        checkOutput("frame_vsync_low", vs_low, 32);
        checkOutput("frame_vblank", vb_n, 64);

        // pix_ce every 4th clk: hsync low lasts 12 clks
        k = 0;
        while (hsync && k < 8 * FRAME) begin
            applyStimulus(1'b0, 1'b1, (k % 4) == 0);
            k++;
        end
        w = 0;
        while (!hsync && w < 100) begin
            applyStimulus(1'b0, 1'b1, (k % 4) == 0);
            k++;
            w++;
        end
        checkOutput("slow_hsync_width", w, 12);

        // Drop vga_en inside both sync pulses, then re-enable
        runTo(11, 5);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkIdle("dis");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkIdle("reen_arm");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkRestart("reen");

        // Reset mid-frame with vga_en held high
        runTo(3, 2);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkIdle("midrst");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkIdle("midrst_arm");
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkRestart("midrst_restart");

        // Randomized enable/reset/pix_ce traffic, checked by the model
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) mode = $urandom_range(0, 2);
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 79) != 0);
            case (mode)
                0:       c = 1'b1;
                1:       c = $urandom_range(0, 1) == 1;
                default: c = ($urandom_range(0, 2) == 0);
            endcase
            applyStimulus(r, e, c);
        end

        @(negedge clk);
        chk_on = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
